// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch stage
package cpu_pkg;
  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_DROP,
    ST_HOLD,
    ST_HALT
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between fetch and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, inst} buffer that absorbs a fetch during a stall
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [31:0]       pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              full_o,
  output logic [31:0]       pc_o,
  output logic [INST_W-1:0] inst_o
);
  logic              full_q;
  logic [31:0]       pc_q;
  logic [INST_W-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, single-outstanding imem requests, skid, redirect
// Optional zero-instruction halt detection is built with FETCH_HALT_DETECT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  fetch_stage_if.master     imem,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic [INST_W-1:0] if_inst,
  output logic              halt
);
  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d, pend_pc_q, pend_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_pc_q, if_pc_d, if_pc4_q, if_pc4_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic              skid_load, skid_clear, skid_full;
  logic [31:0]       skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              slot_free, present;
  logic [31:0]       ld_pc;
  logic [INST_W-1:0] ld_inst;
`ifdef FETCH_HALT_DETECT_EN
  logic              halt_q, halt_d;
`endif

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .inst_i  (imem.imem_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  assign slot_free      = !if_valid_q || !stall;
  assign imem.imem_req  = !rst && (state_q == ST_REQ || state_q == ST_DROP);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_inst_d  = if_inst_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    present    = 1'b0;
    ld_pc      = pc_q;
    ld_inst    = imem.imem_rdata;
`ifdef FETCH_HALT_DETECT_EN
    halt_d     = halt_q;
`endif
    if (redirect) begin
      if_valid_d = 1'b0;
      skid_clear = 1'b0 | 1'b1;
      case (state_q)
        ST_REQ: begin
          // An unacked request must stay on the bus, so park the target until the late ack.
          if (imem.imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem.imem_ack) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else begin
            pend_pc_d = redirect_pc;
          end
        end
        default: begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end
      endcase
`ifdef FETCH_HALT_DETECT_EN
      halt_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem.imem_ack) begin
            pc_d = pc_q + PC_INC;
            if (slot_free) begin
              present = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end else if (slot_free) begin
            if_valid_d = 1'b0;
          end
        end
        ST_DROP: begin
          if_valid_d = 1'b0;
          if (imem.imem_ack) begin
            pc_d    = pend_pc_q;
            state_d = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (slot_free && skid_full) begin
            present    = 1'b1;
            ld_pc      = skid_pc;
            ld_inst    = skid_inst;
            skid_clear = 1'b1;
            state_d    = ST_REQ;
          end
        end
        default: begin
          if (slot_free) if_valid_d = 1'b0;
        end
      endcase
      if (present) begin
        if_valid_d = 1'b1;
        if_pc_d    = ld_pc;
        if_pc4_d   = ld_pc + PC_INC;
        if_inst_d  = ld_inst;
`ifdef FETCH_HALT_DETECT_EN
        if (ld_inst == '0) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_inst_q  <= if_inst_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_pc4   = if_pc4_q;
  assign if_inst  = if_inst_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage with a program-order model
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_HALT_DETECT_EN
  localparam logic [31:0] KEY = 32'h0000_0001;
`else
  localparam logic [31:0] KEY = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc, if_pc4, if_inst;
  logic        halt;

  fetch_stage_if imem ();

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst),
    .halt        (halt)
  );

  // Memory: ack after 'lat' waiting cycles; word = address ^ KEY unless the zero slot is armed
  int          lat = 0;
  int          wait_cnt = 0;
  logic        zero_en = 1'b0;
  logic [31:0] zero_addr = 32'h0;

  assign imem.imem_ack   = imem.imem_req && (wait_cnt >= lat);
  assign imem.imem_rdata = (zero_en && imem.imem_addr == zero_addr) ? 32'h0 : (imem.imem_addr ^ KEY);

  always @(posedge clk) begin
    if (!imem.imem_req || imem.imem_ack) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (zero_en && a == zero_addr) return 32'h0;
    return a ^ KEY;
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Reference model: decode must accept the program-order stream, restarting at each redirect target
  logic [31:0] exp_pc = RST_PC;
  logic        p_redir = 1'b0, p_hold = 1'b0, p_pend = 1'b0;
  logic [31:0] h_pc, h_pc4, h_inst, pend_addr;
  int          n_acc = 0;

  task automatic model_check();
    if (rst) begin
      exp_pc  = RST_PC;
      p_redir = 1'b0;
      p_hold  = 1'b0;
      p_pend  = 1'b0;
      return;
    end
    if (p_redir) chk1("flush_valid", if_valid, 1'b0);
    if (p_hold) begin
      chk("hold_pc", if_pc, h_pc);
      chk("hold_pc4", if_pc4, h_pc4);
      chk("hold_inst", if_inst, h_inst);
    end
    if (p_pend) begin
      chk1("req_held", imem.imem_req, 1'b1);
      chk("addr_held", imem.imem_addr, pend_addr);
    end
    if (if_valid) begin
      chk("pc4", if_pc4, if_pc + 32'd4);
      chk("inst", if_inst, mem_word(if_pc));
    end
    if (if_valid && !stall) begin
      chk("order", if_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (redirect) exp_pc = redirect_pc;
    p_redir   = redirect;
    p_hold    = if_valid && stall && !redirect;
    h_pc      = if_pc;
    h_pc4     = if_pc4;
    h_inst    = if_inst;
    p_pend    = imem.imem_req && !imem.imem_ack;
    pend_addr = imem.imem_addr;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #2;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_req", imem.imem_req, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk1("rst_halt", halt, 1'b0);
    rst = 1'b0;

    // Zero-wait streaming, then a 3-cycle stall while 8 is presented
    drive(0, 0, 0); chk1("first_req", imem.imem_req, 1'b1); chk("first_addr", imem.imem_addr, RST_PC); adv();
    drive(0, 0, 0); chk("seq0_pc", if_pc, 32'h0); chk("seq0_inst", if_inst, 32'h0 ^ KEY); adv();
    drive(0, 0, 0); chk("seq4_pc", if_pc, 32'h4); adv();
    drive(1, 0, 0); chk("seq8_pc", if_pc, 32'h8); chk("skid_fetch_addr", imem.imem_addr, 32'hC); adv();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0); chk("stall_pc", if_pc, 32'h8); chk1("stall_req", imem.imem_req, 1'b0); adv();
    end
    drive(0, 0, 0); chk("release_pc", if_pc, 32'h8); adv();
    drive(0, 0, 0); chk("skid_out_pc", if_pc, 32'hC); chk("after_skid_addr", imem.imem_addr, 32'h10); adv();

    // Two-cycle memory: redirects while requests are outstanding
    lat = 2;
    drive(0, 1, 32'h10); adv();
    drive(0, 0, 0); chk1("drop_valid", if_valid, 1'b0); chk("drop_addr", imem.imem_addr, 32'h14); adv();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); chk("tgt_addr", imem.imem_addr, 32'h10); adv();
    drive(0, 1, 32'h100); adv();
    drive(0, 0, 0); chk1("late_valid", if_valid, 1'b0); chk("late_addr", imem.imem_addr, 32'h10); adv();
    lat = 0;
    drive(0, 0, 0); chk("redir_addr", imem.imem_addr, 32'h100); chk1("redir_valid", if_valid, 1'b0); adv();

    // Redirect together with stall while holding a skid entry
    drive(1, 0, 0); chk("pre_hold_pc", if_pc, 32'h100); adv();
    drive(1, 1, 32'h200); chk1("hold_req", imem.imem_req, 1'b0); adv();
    drive(0, 0, 0); chk1("hr_valid", if_valid, 1'b0); chk("hr_addr", imem.imem_addr, 32'h200); adv();
    drive(0, 0, 0); chk("hr_pc", if_pc, 32'h200); adv();

    // Zero instruction at 0x20
    zero_addr = 32'h20;
    zero_en   = 1'b1;
    drive(0, 1, 32'h18); adv();
    drive(0, 0, 0); chk("z_addr", imem.imem_addr, 32'h18); adv();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); chk("zero_pc", if_pc, 32'h20); chk("zero_inst", if_inst, 32'h0);
`ifdef FETCH_HALT_DETECT_EN
    chk1("halt_req0", imem.imem_req, 1'b0); adv();
    zero_en = 1'b0;
    drive(0, 0, 0); chk1("halt_set", halt, 1'b1); chk1("halt_req1", imem.imem_req, 1'b0); adv();
    drive(0, 0, 0); chk1("halt_req2", imem.imem_req, 1'b0); adv();
    drive(0, 1, 32'h40); adv();
    drive(0, 0, 0); chk1("halt_clr", halt, 1'b0); chk("resume_addr", imem.imem_addr, 32'h40); adv();
    drive(0, 0, 0); chk("resume_pc", if_pc, 32'h40); adv();
`else
    chk1("nop_halt", halt, 1'b0); chk("nop_addr", imem.imem_addr, 32'h24); adv();
    zero_en = 1'b0;
    drive(0, 0, 0); chk("nop_next_pc", if_pc, 32'h24); adv();
`endif

    // PC wrap at the top of the address space
    drive(0, 1, 32'hFFFF_FFF8); adv();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); chk("wrap_last_pc", if_pc, 32'hFFFF_FFF8); adv();
    drive(0, 0, 0); chk("wrap_pc4", if_pc4, 32'h0); chk("wrap_addr", imem.imem_addr, 32'h0); adv();
    drive(0, 0, 0); chk("wrap_pc", if_pc, 32'h0); adv();

    // Reset while a request to 0x3C is outstanding
    drive(0, 1, 32'h3C); adv();
    lat = 3;
    drive(0, 0, 0); chk("pre_rst_addr", imem.imem_addr, 32'h3C); chk1("pre_rst_req", imem.imem_req, 1'b1); adv();
    rst = 1'b1;
    drive(0, 0, 0); chk1("rst_req_force", imem.imem_req, 1'b0); adv();
    chk1("rst2_valid", if_valid, 1'b0);
    chk("rst2_pc", if_pc, 32'h0);
    chk("rst2_pc4", if_pc4, 32'h0);
    chk("rst2_inst", if_inst, 32'h0);
    chk1("rst2_halt", halt, 1'b0);
    rst = 1'b0;
    lat = 0;
    drive(0, 0, 0); chk("rst2_first_addr", imem.imem_addr, RST_PC); chk1("rst2_first_req", imem.imem_req, 1'b1); adv();

    // Randomized traffic against the program-order model
    n_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        s, r;
      logic [31:0] rpc;
      if (wait_cnt == 0) lat = int'($urandom_range(0, 3));
      s   = ($urandom_range(0, 9) < 3);
      r   = ($urandom_range(0, 99) < 6);
      rpc = $urandom_range(0, 1023) << 2;
      drive(s, r, rpc);
      adv();
    end
    chk1("random_progress", n_acc > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
